// File: rtl/cs_load_sequencer.sv
// rtl/cs_load_sequencer.sv - control-store loader: fetches 16-bit words, packs 4 per 64-bit word, writes them
module cs_load_sequencer #(
    parameter int LMA_W  = 13,
    parameter int WR_REC = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    output logic             MREQ,
    output logic [LMA_W-1:0] MADDR,
    input  logic             MACK,
    input  logic [15:0]      MDATA,
    output logic             CSWE,
    output logic [LMA_W-3:0] CSADDR,
    output logic [63:0]      CSDATA,
    output logic             LCS_n,
    output logic             BUSY,
    output logic             DONE
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_RECOV = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    localparam logic [1:0] REC_LAST = (WR_REC > 0) ? 2'(WR_REC - 1) : 2'd0;

    logic [2:0]       r_state;
    logic [LMA_W-1:0] r_lma;
    logic [63:0]      r_asm;
    logic [LMA_W-3:0] r_csaddr;
    logic [1:0]       r_rec;
    logic [2:0]       w_post;

    // The LMA wrapping back to zero is the only end-of-load condition.
    assign w_post = (r_lma == '0) ? S_FIN : S_REQ;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state  <= S_IDLE;
            r_lma    <= '0;
            r_asm    <= '0;
            r_csaddr <= '0;
            r_rec    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_lma <= '0;
                    if (START) r_state <= S_REQ;
                end
                S_REQ: begin
                    if (MACK) begin
                        case (r_lma[1:0])
                            2'd0:    r_asm[63:48] <= MDATA;
                            2'd1:    r_asm[47:32] <= MDATA;
                            2'd2:    r_asm[31:16] <= MDATA;
                            default: r_asm[15:0]  <= MDATA;
                        endcase
                        r_lma <= r_lma + 1'b1;
                        if (r_lma[1:0] == 2'd3) begin
                            r_state  <= S_WRITE;
                            r_csaddr <= r_lma[LMA_W-1:2];
                        end
                    end
                end
                S_WRITE: begin
                    if (WR_REC > 0) begin
                        r_state <= S_RECOV;
                        r_rec   <= REC_LAST;
                    end else begin
                        r_state <= w_post;
                    end
                end
                S_RECOV: begin
                    if (r_rec == 2'd0) r_state <= w_post;
                    else               r_rec   <= r_rec - 1'b1;
                end
                S_FIN:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign MREQ   = (r_state == S_REQ);
    assign MADDR  = r_lma;
    assign CSWE   = (r_state == S_WRITE);
    assign CSADDR = r_csaddr;
    assign CSDATA = r_asm;
    assign LCS_n  = !((r_state == S_REQ) || (r_state == S_WRITE) || (r_state == S_RECOV));
    assign BUSY   = (r_state != S_IDLE);
    assign DONE   = (r_state == S_FIN);

endmodule

// File: tb/tb_cs_load_sequencer.sv
// tb/tb_cs_load_sequencer.sv - randomized self-checking bench for cs_load_sequencer
module tb_cs_load_sequencer;

    localparam int LMA_W  = 4;
    localparam int WR_REC = 1;
    localparam int NW     = 1 << LMA_W;
    localparam int NG     = NW / 4;

    logic             CLK = 1'b0;
    logic             RESET = 1'b0;
    logic             START = 1'b0;
    logic             MREQ;
    logic [LMA_W-1:0] MADDR;
    logic             MACK = 1'b0;
    logic [15:0]      MDATA = 16'h0;
    logic             CSWE;
    logic [LMA_W-3:0] CSADDR;
    logic [63:0]      CSDATA;
    logic             LCS_n;
    logic             BUSY;
    logic             DONE;

    bit          clk_en = 1'b0;
    int          total = 0;
    int          bad = 0;
    logic [63:0] first_data;

    always #5 if (clk_en) CLK = ~CLK;

    cs_load_sequencer #(.LMA_W(LMA_W), .WR_REC(WR_REC)) dut (
        .CLK(CLK), .RESET(RESET), .START(START),
        .MREQ(MREQ), .MADDR(MADDR), .MACK(MACK), .MDATA(MDATA),
        .CSWE(CSWE), .CSADDR(CSADDR), .CSDATA(CSDATA),
        .LCS_n(LCS_n), .BUSY(BUSY), .DONE(DONE)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_mreq"},   64'(MREQ),   64'd0);
        chk({tag, "_maddr"},  64'(MADDR),  64'd0);
        chk({tag, "_cswe"},   64'(CSWE),   64'd0);
        chk({tag, "_csaddr"}, 64'(CSADDR), 64'd0);
        chk({tag, "_csdata"}, CSDATA,      64'd0);
        chk({tag, "_lcs_n"},  64'(LCS_n),  64'd1);
        chk({tag, "_busy"},   64'(BUSY),   64'd0);
        chk({tag, "_done"},   64'(DONE),   64'd0);
    endtask

    // One load against a memory model; wait_for[a] is the number of stall cycles before address a is acked.
    task automatic do_load(input bit rnd, input int abort_grp, input int slow_addr, output int done_at);
        logic [15:0] mem[NW];
        int          wait_for[NW];
        logic [63:0] exp_data[NG];
        int exp_addr = 0;
        int wait_left;
        int waits = 0;
        int nwr = 0;
        int lcs_low = 0;
        int k = 0;
        done_at = -1;
        for (int i = 0; i < NW; i++) begin
            mem[i]      = rnd ? 16'($urandom) : 16'(i);
            wait_for[i] = rnd ? int'($urandom_range(0, 3)) : 0;
            if (i == slow_addr) wait_for[i] = 3;
        end
        for (int g = 0; g < NG; g++)
            exp_data[g] = {mem[4*g], mem[4*g+1], mem[4*g+2], mem[4*g+3]};
        wait_left = wait_for[0];
        @(negedge CLK);
        START = 1'b1;
        while (k < 300) begin
            @(negedge CLK);
            k++;
            if (MREQ) chk("maddr", 64'(MADDR), 64'(exp_addr));
            if (CSWE) begin
                chk("cswe_with_mreq", 64'(MREQ), 64'd0);
                chk("csaddr", 64'(CSADDR), 64'(nwr));
                chk("csdata", CSDATA, (nwr < NG) ? exp_data[nwr] : 64'hx);
                if (nwr == 0) first_data = CSDATA;
                nwr++;
                if (nwr == abort_grp + 1) begin
                    MACK  = 1'b0;
                    START = 1'b0;
                    RESET = 1'b1;
                    #1;
                    chk_reset("midload");
                    @(negedge CLK);
                    chk_reset("midload_held");
                    RESET = 1'b0;
                    return;
                end
            end
            if (!LCS_n) lcs_low++;
            if (DONE) begin
                done_at = k;
                break;
            end
            START = BUSY ? 1'($urandom) : 1'b0;
            if (MREQ && exp_addr < NW) begin
                if (wait_left == 0) begin
                    MACK  = 1'b1;
                    MDATA = mem[exp_addr];
                    exp_addr++;
                    if (exp_addr < NW) wait_left = wait_for[exp_addr];
                end else begin
                    MACK  = 1'b0;
                    MDATA = 16'($urandom);
                    wait_left--;
                    waits++;
                end
            end else begin
                MACK  = rnd ? 1'($urandom) : 1'b0;
                MDATA = 16'($urandom);
            end
        end
        MACK  = 1'b0;
        START = 1'b0;
        chk("write_count", 64'(nwr), 64'(NG));
        chk("done_cycle", 64'(done_at), 64'(NW + waits + NG * (1 + WR_REC) + 1));
        chk("lcs_low_cycles", 64'(lcs_low), 64'(NW + waits + NG * (1 + WR_REC)));
        @(negedge CLK);
        chk("post_busy", 64'(BUSY), 64'd0);
        chk("post_done", 64'(DONE), 64'd0);
        chk("post_lcs_n", 64'(LCS_n), 64'd1);
        chk("post_maddr", 64'(MADDR), 64'd0);
    endtask

    initial begin
        int d;
        #2 RESET = 1'b1;
        #1 chk_reset("async_reset");
        clk_en = 1'b1;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            chk("idle_mreq", 64'(MREQ), 64'd0);
            chk("idle_lcs_n", 64'(LCS_n), 64'd1);
        end

        do_load(1'b0, -1, -1, d);
        chk("full_done_at", 64'(d), 64'd25);
        chk("full_first_csdata", first_data, 64'h0000000100020003);

        do_load(1'b0, -1, 2, d);
        chk("wait_done_at", 64'(d), 64'd28);

        do_load(1'b0, 1, -1, d);
        do_load(1'b0, -1, -1, d);
        chk("restart_first_csdata", first_data, 64'h0000000100020003);

        for (int n = 0; n < 6; n++) do_load(1'b1, -1, -1, d);
        do_load(1'b1, int'($urandom_range(0, NG - 2)), -1, d);
        do_load(1'b1, -1, -1, d);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
